// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, multi-cycle
// divide occupancy of EX, and taken-branch flushes, plus a stall-cycle counter.
module hazard_stall_unit #(
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic             ID_EX_memread,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_is_div,
    input  logic             branch_taken,
    output logic             stall_pc,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             bubble_ID_EX,
    output logic             bubble_EX_MEM,
    output logic             flush_IF_ID,
    output logic             div_busy,
    output logic             div_result_valid,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int CW = $clog2(DIV_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LATENCY - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        DIV_DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          load_use;
    logic          div_stall;

    assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                      ((IF_ID_uses_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                       (IF_ID_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));

    assign div_stall = ((state == IDLE) && ID_EX_is_div) || (state == DIV_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (stall_pc) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    // The busy phase ends on the cycle the counter steps down to zero, which
    // keeps total occupancy at DIV_LATENCY including the entry and done cycles.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (ID_EX_is_div) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (DIV_LATENCY == 2) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                cnt_next = (cnt == '0) ? '0 : cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // While EX holds a divide (including its done cycle) branch and load-use
    // inputs describe nothing real and are ignored.
    always_comb begin
        stall_pc         = 1'b0;
        stall_IF_ID      = 1'b0;
        stall_ID_EX      = 1'b0;
        bubble_ID_EX     = 1'b0;
        bubble_EX_MEM    = 1'b0;
        flush_IF_ID      = 1'b0;
        div_busy         = 1'b0;
        div_result_valid = 1'b0;
        if (div_stall) begin
            stall_pc      = 1'b1;
            stall_IF_ID   = 1'b1;
            stall_ID_EX   = 1'b1;
            bubble_EX_MEM = 1'b1;
            div_busy      = 1'b1;
        end else if (state == DIV_DONE) begin
            div_result_valid = 1'b1;
        end else if (branch_taken) begin
            flush_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
        end else if (load_use) begin
            stall_pc     = 1'b1;
            stall_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: load-use, x0 exemption, branch
// priority, a full 33-cycle divide, and reset in the middle of a divide.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  IF_ID_rs1 = '0;
    logic [4:0]  IF_ID_rs2 = '0;
    logic        IF_ID_uses_rs1 = 1'b0;
    logic        IF_ID_uses_rs2 = 1'b0;
    logic        ID_EX_memread = 1'b0;
    logic [4:0]  ID_EX_rd = '0;
    logic        ID_EX_is_div = 1'b0;
    logic        branch_taken = 1'b0;
    logic        stall_pc, stall_IF_ID, stall_ID_EX, bubble_ID_EX;
    logic        bubble_EX_MEM, flush_IF_ID, div_busy, div_result_valid;
    logic [31:0] stall_cycles;
    logic [7:0]  out_vec;

    int compare_count  = 0;
    int mismatch_count = 0;
    int exp_stalls     = 0;

    // Output bit order: stall_pc, stall_IF_ID, stall_ID_EX, bubble_ID_EX,
    // bubble_EX_MEM, flush_IF_ID, div_busy, div_result_valid
    localparam logic [7:0] QUIET  = 8'b0000_0000;
    localparam logic [7:0] LU     = 8'b1101_0000;
    localparam logic [7:0] DIVST  = 8'b1110_1010;
    localparam logic [7:0] DONE   = 8'b0000_0001;
    localparam logic [7:0] BRANCH = 8'b0001_0100;

    assign out_vec = {stall_pc, stall_IF_ID, stall_ID_EX, bubble_ID_EX,
                      bubble_EX_MEM, flush_IF_ID, div_busy, div_result_valid};

    hazard_stall_unit #(.DIV_LATENCY(33), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .IF_ID_rs1        (IF_ID_rs1),
        .IF_ID_rs2        (IF_ID_rs2),
        .IF_ID_uses_rs1   (IF_ID_uses_rs1),
        .IF_ID_uses_rs2   (IF_ID_uses_rs2),
        .ID_EX_memread    (ID_EX_memread),
        .ID_EX_rd         (ID_EX_rd),
        .ID_EX_is_div     (ID_EX_is_div),
        .branch_taken     (branch_taken),
        .stall_pc         (stall_pc),
        .stall_IF_ID      (stall_IF_ID),
        .stall_ID_EX      (stall_ID_EX),
        .bubble_ID_EX     (bubble_ID_EX),
        .bubble_EX_MEM    (bubble_EX_MEM),
        .flush_IF_ID      (flush_IF_ID),
        .div_busy         (div_busy),
        .div_result_valid (div_result_valid),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic memread, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic uses1, input logic uses2,
                                 input logic is_div, input logic br);
        ID_EX_memread  = memread;
        ID_EX_rd       = rd;
        IF_ID_rs1      = rs1;
        IF_ID_rs2      = rs2;
        IF_ID_uses_rs1 = uses1;
        IF_ID_uses_rs2 = uses2;
        ID_EX_is_div   = is_div;
        branch_taken   = br;
    endtask

    // Inputs are set just after a rising edge; outputs and the counter are
    // sampled mid-cycle, then the bench advances to just after the next edge.
    task automatic stepCycle(input string tag, input logic [7:0] expected);
        @(negedge clk);
        checkOutput({tag, " count"}, stall_cycles, 32'(exp_stalls));
        checkOutput(tag, 32'(out_vec), 32'(expected));
        if (expected[7]) exp_stalls++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        checkOutput("reset outs", 32'(out_vec), 32'(QUIET));
        checkOutput("reset count", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); stepCycle("idle", QUIET);
        applyStimulus(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0); stepCycle("lu_rs2", LU);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); stepCycle("after_lu", QUIET);
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0); stepCycle("x0_rd", QUIET);
        applyStimulus(1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0); stepCycle("rs1_unused", QUIET);
        applyStimulus(1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0); stepCycle("lu_rs1", LU);
        applyStimulus(0, 5'd7, 5'd7, 5'd7, 1, 1, 0, 0); stepCycle("no_load", QUIET);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1); stepCycle("branch", BRANCH);
        applyStimulus(1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 1); stepCycle("branch_over_lu", BRANCH);

        // Full divide: branch at busy cycle 10 and a load-use at 20 are ignored.
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(i == 20, 5'd4, 5'd4, 5'd0, 1, 0, 1, i == 10);
            stepCycle($sformatf("div_busy%0d", i), DIVST);
        end
        applyStimulus(1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1); stepCycle("div_done", DONE);
        applyStimulus(1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0); stepCycle("lu_after_div", LU);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0); stepCycle("idle2", QUIET);

        // Reset in the middle of a divide.
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
            stepCycle($sformatf("div2_busy%0d", i), DIVST);
        end
        rst_n = 1'b0;
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        #1;
        checkOutput("rst_mid outs", 32'(out_vec), 32'(QUIET));
        checkOutput("rst_mid count", stall_cycles, 32'd0);
        exp_stalls = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 40; i++) begin
            stepCycle($sformatf("post_rst%0d", i), QUIET);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall/flush controller for the 5-stage RV32IM pipeline, complementing operand forwarding. Forwarding resolves RAW hazards whose producer result already sits in EX/MEM or MEM/WB. This block handles the cases forwarding cannot cover: load-use hazards, the multi-cycle DIV/DIVU/REM/REMU occupancy of EX, and taken-branch flushes. It sits beside the ID/EX boundary and drives the PC, IF/ID, ID/EX and EX/MEM write enables and bubble controls.

## Interface
- DIV_LATENCY, 33, cycles EX is occupied by a divide (legal range 2..64)
- CNT_W, 32, width of the stall-cycle performance counter
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- IF_ID_rs1, IF_ID_rs2  in  5  source registers of the instruction in ID
- IF_ID_uses_rs1, IF_ID_uses_rs2  in  1  source actually read by that instruction
- ID_EX_memread  in  1  instruction in EX is a load
- ID_EX_rd  in  5  destination of the instruction in EX
- ID_EX_is_div  in  1  instruction in EX is DIV/DIVU/REM/REMU
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall_pc  out  1  hold PC
- stall_IF_ID  out  1  hold IF/ID register
- stall_ID_EX  out  1  hold ID/EX register
- bubble_ID_EX  out  1  load a NOP into ID/EX
- bubble_EX_MEM  out  1  load a NOP into EX/MEM
- flush_IF_ID  out  1  replace IF/ID with NOP
- div_busy  out  1  divider occupying EX
- div_result_valid  out  1  divider result to be latched into EX/MEM this cycle
- stall_cycles  out  CNT_W  count of cycles with stall_pc=1

## Operation
- FSM states: IDLE, DIV_BUSY, DIV_DONE. Down-counter `cnt` is $clog2(DIV_LATENCY) bits wide.
- IDLE → DIV_BUSY when ID_EX_is_div=1. On that transition, load cnt=DIV_LATENCY-2.
- DIV_BUSY: decrement cnt each cycle. When cnt==0, go to DIV_DONE.
- DIV_DONE → IDLE unconditionally after one cycle.
- Divide occupancy is therefore exactly DIV_LATENCY cycles: the entry cycle, the DIV_BUSY cycles, and DIV_DONE.
- The divide stall is asserted in IDLE with ID_EX_is_div=1, and throughout DIV_BUSY. It drives:
  - stall_pc=1, stall_IF_ID=1, stall_ID_EX=1, bubble_EX_MEM=1, div_busy=1
  - bubble_ID_EX=0
- DIV_DONE: all stalls deasserted; div_result_valid=1, div_busy=0.
- load_use = ID_EX_memread & (ID_EX_rd≠0) & ((IF_ID_uses_rs1 & rd==rs1) | (IF_ID_uses_rs2 & rd==rs2)).
- Load-use stall, evaluated only when no divide stall is active: stall_pc=1, stall_IF_ID=1, bubble_ID_EX=1, for exactly one cycle per occurrence.
- Branch flush: branch_taken=1 with no divide stall → flush_IF_ID=1 and bubble_ID_EX=1.
  - Branch overrides load-use: stall_pc=0 and stall_IF_ID=0 so the redirect PC loads.
- branch_taken is ignored while the divide stall is active; EX holds a divide, not a branch.
- ID_EX_is_div is ignored outside IDLE; the held divide must not retrigger.
- stall_cycles increments by 1 (wrapping modulo 2^CNT_W) on every rising edge where stall_pc=1.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, stall_cycles=0.
  - All combinational outputs then evaluate with state=IDLE; with inputs quiescent they are 0.
- Reset asserted mid-divide aborts the divide immediately: div_busy=0 and no div_result_valid pulse.
- Outputs are combinational from registered state plus current inputs. There is no register latency on stall/flush decisions.
- Divide with DIV_LATENCY=N: div_busy=1 for N-1 cycles starting in the cycle ID_EX_is_div first rises; div_result_valid=1 in cycle N.
- Back-to-back divides: the second divide enters EX only after DIV_DONE, so it starts a fresh sequence from IDLE.
- A load-use stall immediately after DIV_DONE is evaluated normally in the following IDLE cycle.

## Test plan
- Load-use stall: ID_EX_memread=1, ID_EX_rd=5, IF_ID_rs2=5, uses_rs2=1 → one cycle of stall_pc=stall_IF_ID=bubble_ID_EX=1; stall_cycles goes 0→1.
- x0 exemption: same as above with rd=0 → no stall. uses_rs1=0 with rs1 matching rd → no stall.
- Divide with DIV_LATENCY=33: ID_EX_is_div pulses → div_busy=1 for 32 cycles, then div_result_valid=1 for 1 cycle, then IDLE; stall_cycles=32.
- Branch vs load-use: branch_taken=1 and load_use=1 together → flush_IF_ID=1, bubble_ID_EX=1, stall_pc=0.
- Branch during divide: branch_taken=1 while div_busy=1 → no flush; the divide completes on schedule.
- Reset mid-divide: rst_n low at busy cycle 10 → all outputs 0 at once; after release with inputs idle, div_result_valid never pulses and stall_cycles=0.
